hpu_pip_if_ibuf: RTL and testbench

//  Instruction buffer between the fetch stage (pip_if) and the decode stage (pip_id).
//  - Accepts fetch packets of up to two 32-bit instructions per cycle.
//  - Queues them in order with PC and fetch-exception tag.
//  - Presents the two oldest to decode; decode retires 0..2 per cycle.
//  - Decouples fetch stalls from decode stalls; emptied in one cycle on pipeline redirect.

---
 rtl/hpu_pip_if_ibuf.sv | 129 ++++++++++++
 tb/tb_hpu_pip_if_ibuf.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hpu_pip_if_ibuf.sv
// rtl/hpu_pip_if_ibuf.sv - instruction buffer between fetch and decode
//
// Circular buffer of {pc, inst, excp} entries. Fetch writes up to two slots
// per cycle; decode sees the two oldest entries combinationally and retires
// 0..2 of them per cycle. A flush empties the buffer in one cycle.
//
// Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   flush_i              discard all entries (wins over push and pop)
//   if_vld_i / if_rdy_o  fetch packet handshake
//   if_pc_i              PC of slot0; slot1 PC is if_pc_i+4
//   if_inst_i            {slot1, slot0} instructions
//   if_msk_i             per-slot valid of the fetch packet
//   if_excp_i            fetch fault, tags every written slot
//   id_vld_o             [0]=head valid, [1]=head+1 valid
//   id_pc_o, id_inst_o   {head+1, head} PC / instruction, zero when invalid
//   id_excp_o            {head+1, head} exception tag, zero when invalid
//   id_pop_i             entries retired by decode this cycle
//   cnt_o                current occupancy
module hpu_pip_if_ibuf #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned INST_W = 32,
    parameter int unsigned PC_W   = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    flush_i,
    input  logic                    if_vld_i,
    output logic                    if_rdy_o,
    input  logic [PC_W-1:0]         if_pc_i,
    input  logic [2*INST_W-1:0]     if_inst_i,
    input  logic [1:0]              if_msk_i,
    input  logic                    if_excp_i,
    output logic [1:0]              id_vld_o,
    output logic [2*PC_W-1:0]       id_pc_o,
    output logic [2*INST_W-1:0]     id_inst_o,
    output logic [1:0]              id_excp_o,
    input  logic [1:0]              id_pop_i,
    output logic [$clog2(DEPTH):0]  cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic              excp_mem [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;

    logic [AW-1:0] wr_ptr1, rd_ptr1;
    logic [CW-1:0] free_slots;
    logic          accept;
    logic [1:0]    npush, nvld, npop;

    assign wr_ptr1 = wr_ptr + AW'(1);
    assign rd_ptr1 = rd_ptr + AW'(1);

    // Ready looks only at the registered count so it never depends on id_pop_i.
    assign free_slots = CW'(DEPTH) - cnt;
    assign if_rdy_o   = (free_slots >= CW'(2));
    assign accept     = if_vld_i & if_rdy_o & ~flush_i;
    assign npush      = accept ? ({1'b0, if_msk_i[0]} + {1'b0, if_msk_i[1]}) : 2'd0;

    // An excepting head is presented alone so decode handles the fault first.
    assign id_vld_o[0] = (cnt >= CW'(1));
    assign id_vld_o[1] = (cnt >= CW'(2)) & ~excp_mem[rd_ptr];

    assign nvld = {1'b0, id_vld_o[0]} + {1'b0, id_vld_o[1]};
    assign npop = flush_i ? 2'd0 : ((id_pop_i > nvld) ? nvld : id_pop_i);

    assign id_pc_o[PC_W-1:0]        = id_vld_o[0] ? pc_mem[rd_ptr]    : '0;
    assign id_pc_o[2*PC_W-1:PC_W]   = id_vld_o[1] ? pc_mem[rd_ptr1]   : '0;
    assign id_inst_o[INST_W-1:0]    = id_vld_o[0] ? inst_mem[rd_ptr]  : '0;
    assign id_inst_o[2*INST_W-1:INST_W] = id_vld_o[1] ? inst_mem[rd_ptr1] : '0;
    assign id_excp_o[0]             = id_vld_o[0] & excp_mem[rd_ptr];
    assign id_excp_o[1]             = id_vld_o[1] & excp_mem[rd_ptr1];

    assign cnt_o = cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(npush);
            rd_ptr <= rd_ptr + AW'(npop);
            cnt    <= cnt + CW'(npush) - CW'(npop);
        end
    end

    // Storage is not reset; validity comes from cnt alone.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            case (if_msk_i)
                2'b11: begin
                    pc_mem[wr_ptr]    <= if_pc_i;
                    inst_mem[wr_ptr]  <= if_inst_i[INST_W-1:0];
                    excp_mem[wr_ptr]  <= if_excp_i;
                    pc_mem[wr_ptr1]   <= if_pc_i + PC_W'(4);
                    inst_mem[wr_ptr1] <= if_inst_i[2*INST_W-1:INST_W];
                    excp_mem[wr_ptr1] <= if_excp_i;
                end
                2'b01: begin
                    pc_mem[wr_ptr]    <= if_pc_i;
                    inst_mem[wr_ptr]  <= if_inst_i[INST_W-1:0];
                    excp_mem[wr_ptr]  <= if_excp_i;
                end
                2'b10: begin
                    pc_mem[wr_ptr]    <= if_pc_i + PC_W'(4);
                    inst_mem[wr_ptr]  <= if_inst_i[2*INST_W-1:INST_W];
                    excp_mem[wr_ptr]  <= if_excp_i;
                end
                default: ;
            endcase
        end
    end

    // Decode may never retire more entries than are presented as valid.
    a_pop_legal: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !flush_i |-> (id_pop_i <= nvld));

endmodule

// File: tb/tb_hpu_pip_if_ibuf.sv
// tb/tb_hpu_pip_if_ibuf.sv - self-checking bench for hpu_pip_if_ibuf
module tb_hpu_pip_if_ibuf;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic        if_vld_i;
    logic        if_rdy_o;
    logic [31:0] if_pc_i;
    logic [63:0] if_inst_i;
    logic [1:0]  if_msk_i;
    logic        if_excp_i;
    logic [1:0]  id_vld_o;
    logic [63:0] id_pc_o;
    logic [63:0] id_inst_o;
    logic [1:0]  id_excp_o;
    logic [1:0]  id_pop_i;
    logic [3:0]  cnt_o;

    always #5 clk = ~clk;

    hpu_pip_if_ibuf #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n_i),
        .flush_i   (flush_i),
        .if_vld_i  (if_vld_i),
        .if_rdy_o  (if_rdy_o),
        .if_pc_i   (if_pc_i),
        .if_inst_i (if_inst_i),
        .if_msk_i  (if_msk_i),
        .if_excp_i (if_excp_i),
        .id_vld_o  (id_vld_o),
        .id_pc_o   (id_pc_o),
        .id_inst_o (id_inst_o),
        .id_excp_o (id_excp_o),
        .id_pop_i  (id_pop_i),
        .cnt_o     (cnt_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
    } ent_t;

    typedef struct {
        logic        flush;
        logic        vld;
        logic [31:0] pc;
        logic [63:0] inst;
        logic [1:0]  msk;
        logic        excp;
        logic [1:0]  pop;
        logic [1:0]  e_vld;
        logic [31:0] e_pc0;
        logic [31:0] e_pc1;
        logic [3:0]  e_cnt;
        logic        e_rdy;
        logic [1:0]  e_excp;
    } vec_t;

    ent_t q[$];
    vec_t vecs[19];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int model_nvld();
        int n = 0;
        if (q.size() >= 1) n++;
        if (q.size() >= 2 && !q[0].excp) n++;
        return n;
    endfunction

    task automatic model_check(input string tag);
        logic [1:0]  ev  = '0;
        logic [63:0] epc = '0;
        logic [63:0] ein = '0;
        logic [1:0]  eex = '0;
        if (q.size() >= 1) begin
            ev[0] = 1'b1; epc[31:0] = q[0].pc; ein[31:0] = q[0].inst; eex[0] = q[0].excp;
        end
        if (q.size() >= 2 && !q[0].excp) begin
            ev[1] = 1'b1; epc[63:32] = q[1].pc; ein[63:32] = q[1].inst; eex[1] = q[1].excp;
        end
        chk({tag, " vld"},  id_vld_o,  ev);
        chk({tag, " pc"},   id_pc_o,   epc);
        chk({tag, " inst"}, id_inst_o, ein);
        chk({tag, " excp"}, id_excp_o, eex);
        chk({tag, " cnt"},  cnt_o,     q.size());
        chk({tag, " rdy"},  if_rdy_o,  (DEPTH - q.size()) >= 2);
        chk({tag, " cnt_le_depth"}, cnt_o <= DEPTH, 1);
    endtask

    // Drives one cycle of inputs, advances the reference queue, and returns #1 after the edge.
    task automatic step(input logic fl, input logic vl, input logic [31:0] pc,
                        input logic [63:0] inst, input logic [1:0] msk,
                        input logic ex, input logic [1:0] pop);
        int  np;
        bit  rdy;
        flush_i = fl; if_vld_i = vl; if_pc_i = pc; if_inst_i = inst;
        if_msk_i = msk; if_excp_i = ex; id_pop_i = pop;
        rdy = (DEPTH - q.size()) >= 2;
        if (fl) begin
            q.delete();
        end else begin
            np = (int'(pop) < model_nvld()) ? int'(pop) : model_nvld();
            repeat (np) void'(q.pop_front());
            if (vl && rdy) begin
                if (msk[0]) q.push_back('{pc, inst[31:0], ex});
                if (msk[1]) q.push_back('{pc + 32'd4, inst[63:32], ex});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush_i = 0; if_vld_i = 0; if_pc_i = 0; if_inst_i = 0;
        if_msk_i = 0; if_excp_i = 0; id_pop_i = 0;
    endtask

    initial begin
        logic [31:0] rpc;
        int          nv;
        logic [1:0]  rmsk;

        vecs[0]  = '{0,1,32'h1000,{32'h00000013,32'h00100093},2'b11,0,0, 2'b11,32'h1000,32'h1004,4'd2,1,2'b00};
        vecs[1]  = '{0,1,32'h1008,64'h11110001_22220001,2'b11,0,0, 2'b11,32'h1000,32'h1004,4'd4,1,2'b00};
        vecs[2]  = '{0,1,32'h1010,64'h11110002_22220002,2'b11,0,0, 2'b11,32'h1000,32'h1004,4'd6,1,2'b00};
        vecs[3]  = '{0,1,32'h1018,64'h11110003_22220003,2'b11,0,0, 2'b11,32'h1000,32'h1004,4'd8,0,2'b00};
        vecs[4]  = '{0,1,32'h1020,64'h11110004_22220004,2'b11,0,0, 2'b11,32'h1000,32'h1004,4'd8,0,2'b00};
        vecs[5]  = '{0,0,32'h0,   64'h0,                2'b00,0,2, 2'b11,32'h1008,32'h100c,4'd6,1,2'b00};
        vecs[6]  = '{1,0,32'h0,   64'h0,                2'b00,0,2, 2'b00,32'h0,   32'h0,   4'd0,1,2'b00};
        vecs[7]  = '{0,1,32'h2000,64'h33330000_44440000,2'b10,0,0, 2'b01,32'h2004,32'h0,   4'd1,1,2'b00};
        vecs[8]  = '{0,0,32'h0,   64'h0,                2'b00,0,1, 2'b00,32'h0,   32'h0,   4'd0,1,2'b00};
        vecs[9]  = '{0,1,32'h3000,64'h55550000_66660000,2'b11,1,0, 2'b01,32'h3000,32'h0,   4'd2,1,2'b01};
        vecs[10] = '{0,0,32'h0,   64'h0,                2'b00,0,1, 2'b01,32'h3004,32'h0,   4'd1,1,2'b01};
        vecs[11] = '{0,0,32'h0,   64'h0,                2'b00,0,1, 2'b00,32'h0,   32'h0,   4'd0,1,2'b00};
        vecs[12] = '{0,1,32'h4000,64'h77770000_88880000,2'b11,0,0, 2'b11,32'h4000,32'h4004,4'd2,1,2'b00};
        vecs[13] = '{0,1,32'h4008,64'h77770001_88880001,2'b11,0,0, 2'b11,32'h4000,32'h4004,4'd4,1,2'b00};
        vecs[14] = '{0,1,32'h4010,64'h77770002_88880002,2'b01,0,0, 2'b11,32'h4000,32'h4004,4'd5,1,2'b00};
        vecs[15] = '{1,1,32'h5000,64'h99990000_aaaa0000,2'b11,0,1, 2'b00,32'h0,   32'h0,   4'd0,1,2'b00};
        vecs[16] = '{0,1,32'h6000,64'hbbbb0000_cccc0000,2'b00,0,0, 2'b00,32'h0,   32'h0,   4'd0,1,2'b00};
        vecs[17] = '{0,1,32'h7000,64'hdddd0000_eeee0000,2'b01,0,0, 2'b01,32'h7000,32'h0,   4'd1,1,2'b00};
        vecs[18] = '{0,1,32'h7100,64'hdddd0001_eeee0001,2'b11,0,1, 2'b11,32'h7100,32'h7104,4'd2,1,2'b00};

        rst_n_i = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        #1;
        chk("reset vld",  id_vld_o,  2'b00);
        chk("reset rdy",  if_rdy_o,  1'b1);
        chk("reset cnt",  cnt_o,     4'd0);
        chk("reset inst", id_inst_o, 64'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].flush, vecs[i].vld, vecs[i].pc, vecs[i].inst,
                 vecs[i].msk, vecs[i].excp, vecs[i].pop);
            chk($sformatf("vec%0d vld", i),  id_vld_o,       vecs[i].e_vld);
            chk($sformatf("vec%0d pc0", i),  id_pc_o[31:0],  vecs[i].e_pc0);
            chk($sformatf("vec%0d pc1", i),  id_pc_o[63:32], vecs[i].e_pc1);
            chk($sformatf("vec%0d cnt", i),  cnt_o,          vecs[i].e_cnt);
            chk($sformatf("vec%0d rdy", i),  if_rdy_o,       vecs[i].e_rdy);
            chk($sformatf("vec%0d excp", i), id_excp_o,      vecs[i].e_excp);
            model_check($sformatf("vec%0d model", i));
        end
        chk("vec0 inst lo", 1'b1, 1'b1 & (vecs[0].inst[31:0] == 32'h00100093));

        // Asynchronous reset between clock edges with entries buffered.
        step(0, 1, 32'h9000, 64'h12345678_9abcdef0, 2'b11, 0, 0);
        chk("pre_areset cnt", cnt_o, 4'd4);
        #2;
        rst_n_i = 1'b0;
        #1;
        q.delete();
        chk("areset cnt", cnt_o,    4'd0);
        chk("areset vld", id_vld_o, 2'b00);
        chk("areset rdy", if_rdy_o, 1'b1);
        idle();
        @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        model_check("post_areset");

        // Random traffic across pointer wrap against the queue model.
        rpc = 32'h8000;
        for (int c = 0; c < 300; c++) begin
            nv   = model_nvld();
            rmsk = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), rpc,
                 {$urandom, $urandom}, rmsk, ($urandom_range(0, 15) == 0),
                 2'($urandom_range(0, nv)));
            model_check($sformatf("rand%0d", c));
            rpc = rpc + 32'd8;
        end

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
